hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller in the ID stage of the 5-stage MIPS pipeline; the sequencing companion to the EX-stage forwarding unit.
- Covers hazards that forwarding cannot: load-use, branches resolved in ID whose operands are still in flight, and control flush on taken branch/jump.
- Drives PC write-enable, IF/ID write-enable, IF/ID flush and the ID/EX bubble insert.
- A small FSM holds multi-cycle stalls so that a 2-cycle stall is not re-decided while it is in progress.

Parameters:
- REG_ADDR_W, 5, register specifier width.
- CNT_WIDTH, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- reg_Rs_ID  input  REG_ADDR_W  rs of the instruction in ID.
- reg_Rt_ID  input  REG_ADDR_W  rt of the instruction in ID.
- use_rt_ID  input  1  ID instruction reads rt as a source (R-type, beq/bne, sw).
- branch_ID  input  1  ID instruction is beq/bne.
- branch_taken_ID  input  1  ID comparator result; valid only when branch_ID=1.
- jump_ID  input  1  ID instruction is j/jal (no register sources).
- reg_write_EX  input  1  EX instruction writes a register.
- mem_read_EX  input  1  EX instruction is a load.
- reg_Rd_EX  input  REG_ADDR_W  muxed destination of the EX instruction.
- mem_read_MEM  input  1  MEM instruction is a load.
- reg_Rd_MEM  input  REG_ADDR_W  destination of the MEM instruction.
- pc_write  output  1  1 = PC updates this cycle.
- IF_ID_write  output  1  1 = IF/ID register loads this cycle.
- IF_ID_flush  output  1  1 = IF/ID is cleared to a nop at the next edge.
- ID_EX_bubble  output  1  1 = ID/EX control fields are zeroed at the next edge.
- stall_active  output  1  1 = a stall cycle is in progress.

Behaviour:
- Reset: the synchronous reset is active-high. While reset=1, outputs are pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_bubble=0, stall_active=0. At the edge, state←IDLE and stall_cnt←0. Reset asserted mid-stall aborts the stall immediately.
- Match rule: matchX(r) = (reg_Rd_X == r) & (reg_Rd_X != 0). Register $0 never causes a hazard. The rt source is considered only if use_rt_ID=1.
- Required stall count N, evaluated only in IDLE; the maximum of the applicable rules is taken:
  - Load-use: mem_read_EX & match EX on rs or rt → 1.
  - Branch on EX ALU result: branch_ID & reg_write_EX & ~mem_read_EX & match EX → 1.
  - Branch on EX load: branch_ID & mem_read_EX & match EX → 2.
  - Branch on MEM load: branch_ID & mem_read_MEM & match MEM → 1.
- FSM states: IDLE, STALL. stall_cnt is 2 bits.
- IDLE with N>0:
  - Outputs this cycle: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, stall_active=1, IF_ID_flush=0.
  - If N=2: stall_cnt←1 and go to STALL. If N=1: remain in IDLE.
- IDLE with N=0: pc_write=1, IF_ID_write=1, ID_EX_bubble=0, stall_active=0. IF_ID_flush = (branch_ID & branch_taken_ID) | jump_ID.
- STALL: stall outputs are held as in IDLE with N>0, independent of inputs. stall_cnt decrements each cycle; when it reaches 0, go to IDLE. In IDLE the hazard is re-evaluated from the then-current inputs.
- Priority: a stall overrides a flush. branch_taken_ID is ignored on any stall cycle, because the branch has not yet resolved.
- Latency: all outputs are combinational from state and inputs (same cycle). Only state and counters are registered.
- Total stall lengths: load-use = 1 cycle; branch on EX ALU = 1; branch on EX load = 2; branch on MEM load = 1.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds output ports stall_count and flush_count, each CNT_WIDTH bits.
  - stall_count increments on every cycle with stall_active=1.
  - flush_count increments on every cycle with IF_ID_flush=1.
  - Both counters saturate at all-ones and clear to 0 on reset.
- When undefined: the ports and counters do not exist. The remaining behaviour is identical.

Test Plan:
- Load-use: lw $t0 in EX (mem_read_EX=1, reg_Rd_EX=8), add in ID with reg_Rs_ID=8 → exactly 1 cycle with pc_write=0, IF_ID_write=0, ID_EX_bubble=1; normal outputs on the next cycle.
- Branch on EX load: mem_read_EX=1, reg_Rd_EX=9, branch_ID=1, reg_Rt_ID=9, use_rt_ID=1 → stall_active=1 for 2 consecutive cycles. In the second cycle the EX/MEM inputs are changed to non-matching values and the stall is still held. IDLE follows.
- $0 and unused rt: reg_Rd_EX=0 with a load in EX, or a match on rt only with use_rt_ID=0 → no stall; pc_write=1.
- Taken branch with no hazard: branch_ID=1, branch_taken_ID=1 → IF_ID_flush=1 for 1 cycle, no bubble. The same stimulus during a stall cycle → IF_ID_flush=0.
- Reset mid-stall: reset=1 on the first cycle of a 2-cycle stall → all outputs 0 during reset. The next cycle is IDLE with pc_write=1 (given no hazard).
- With HAZARD_PERF_CNT_EN: one load-use stall, one 2-cycle branch stall and one jump → stall_count=3, flush_count=1. Preloading to all-ones and stalling again → the counter stays at all-ones.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   ID-stage hazard sequencer for the 5-stage MIPS pipeline. It handles the
//   hazards that EX forwarding cannot resolve:
//   - load-use;
//   - branches resolved in ID whose operands are still in flight;
//   - the IF/ID flush on a taken branch or a jump.
//   A two-state FSM holds the 2-cycle branch-on-EX-load stall, so that stall
//   is not re-decided while it is in progress.
//
// Ports
//   clk, reset          : clock; synchronous active-high reset
//   reg_Rs_ID/Rt_ID     : source specifiers of the ID instruction
//   use_rt_ID           : ID instruction reads rt
//   branch_ID           : ID instruction is beq/bne
//   branch_taken_ID     : ID comparator result
//   jump_ID             : ID instruction is j/jal
//   reg_write_EX        : EX instruction writes a register
//   mem_read_EX         : EX instruction is a load
//   reg_Rd_EX           : destination of the EX instruction
//   mem_read_MEM        : MEM instruction is a load
//   reg_Rd_MEM          : destination of the MEM instruction
//   pc_write            : PC update enable
//   IF_ID_write         : IF/ID load enable
//   IF_ID_flush         : clear IF/ID to a nop
//   ID_EX_bubble        : zero the ID/EX control fields
//   stall_active        : a stall cycle is in progress
//   stall_count         : stall-cycle counter (HAZARD_PERF_CNT_EN only)
//   flush_count         : flush-cycle counter (HAZARD_PERF_CNT_EN only)
//
// Build option
//   HAZARD_PERF_CNT_EN adds saturating performance counters of CNT_WIDTH bits.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] reg_Rs_ID,
  input  logic [REG_ADDR_W-1:0] reg_Rt_ID,
  input  logic                  use_rt_ID,
  input  logic                  branch_ID,
  input  logic                  branch_taken_ID,
  input  logic                  jump_ID,
  input  logic                  reg_write_EX,
  input  logic                  mem_read_EX,
  input  logic [REG_ADDR_W-1:0] reg_Rd_EX,
  input  logic                  mem_read_MEM,
  input  logic [REG_ADDR_W-1:0] reg_Rd_MEM,
  output logic                  pc_write,
  output logic                  IF_ID_write,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_bubble,
  output logic                  stall_active
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  flush_count
`endif
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t     state;
  logic [1:0] stall_cnt;

  logic ex_hit, mem_hit;
  logic need1, need2;
  logic stalling;

  // $0 is hardwired zero and never creates a dependency; rt counts only
  // when the ID instruction actually reads it.
  always_comb begin
    ex_hit  = ((reg_Rd_EX == reg_Rs_ID) && (reg_Rd_EX != '0)) ||
              (use_rt_ID && (reg_Rd_EX == reg_Rt_ID) && (reg_Rd_EX != '0));
    mem_hit = ((reg_Rd_MEM == reg_Rs_ID) && (reg_Rd_MEM != '0)) ||
              (use_rt_ID && (reg_Rd_MEM == reg_Rt_ID) && (reg_Rd_MEM != '0));
  end

  // need2 dominates need1 (maximum of the applicable rules).
  assign need2 = branch_ID & mem_read_EX & ex_hit;
  assign need1 = (mem_read_EX & ex_hit) |
                 (branch_ID & reg_write_EX & ~mem_read_EX & ex_hit) |
                 (branch_ID & mem_read_MEM & mem_hit);

  // In STALL the outputs ignore the inputs; in IDLE the hazard is decided
  // from the current inputs.
  assign stalling = (state == STALL) | need1 | need2;

  // A stall suppresses the flush: an unresolved branch cannot redirect.
  always_comb begin
    pc_write     = ~reset & ~stalling;
    IF_ID_write  = ~reset & ~stalling;
    ID_EX_bubble = ~reset & stalling;
    stall_active = ~reset & stalling;
    IF_ID_flush  = ~reset & ~stalling & ((branch_ID & branch_taken_ID) | jump_ID);
  end

  // One-cycle stalls complete in IDLE; only the 2-cycle stall needs STALL,
  // where stall_cnt counts the remaining stall cycles after the first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stall_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (need2) begin
            stall_cnt <= 2'd1;
            state     <= STALL;
          end
        end
        STALL: begin
          stall_cnt <= stall_cnt - 2'd1;
          if (stall_cnt == 2'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counters: they hold at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_active && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (IF_ID_flush  && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule
